// File: rtl/gyro_sampler.sv
// gyro_sampler: periodic SPI (mode 3) master for an L3G4200D-class gyro.
// It writes CTRL_REG1 once after reset. On every sample tick it burst-reads the
// six rate bytes and publishes signed DX/DY/DZ with a one-cycle VALID strobe.
// Optional feature macro: GYRO_DEADBAND_EN. When it is defined, published values
// strictly inside (DEADBAND_LO, DEADBAND_HI) are forced to zero.
module gyro_sampler #(
    parameter int        SAMPLE_DIV  = 50000,
    parameter int        CLK_DIV     = 25,
    parameter int signed DEADBAND_LO = -42,
    parameter int signed DEADBAND_HI = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MISO,
    output logic               SCLK,
    output logic               MOSI,
    output logic               SS,
    output logic signed [15:0] DX,
    output logic signed [15:0] DY,
    output logic signed [15:0] DZ,
    output logic               VALID,
    output logic               OVERRUN
);

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

    // Sensor command bytes: CTRL_REG1 address, power-on/all-axes value,
    // and read with auto-increment starting at OUT_X_L.
    localparam logic [7:0] CMD_WR_ADDR = 8'h20;
    localparam logic [7:0] CMD_WR_DATA = 8'h0F;
    localparam logic [7:0] CMD_RD      = 8'hE8;

    localparam logic signed [15:0] DB_LO = DEADBAND_LO[15:0];
    localparam logic signed [15:0] DB_HI = DEADBAND_HI[15:0];

`ifdef GYRO_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_CFG,
        ST_WAIT,
        ST_READ,
        ST_PUB
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_LOW,
        PH_HIGH,
        PH_HOLD
    } phase_t;

    // Deadband on a published axis value; a pass-through when the feature is off.
    function automatic logic signed [15:0] deadband(input logic signed [15:0] v);
        if (DB_EN && (v > DB_LO) && (v < DB_HI)) begin
            return '0;
        end
        return v;
    endfunction

    state_t             state, state_nxt;
    phase_t             phase, phase_nxt;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [DIV_W-1:0]   gap_cnt, gap_nxt;
    logic [2:0]         bit_cnt, bit_nxt;
    logic [2:0]         byte_cnt, byte_nxt;
    logic [7:0]         tx_sh, tx_nxt;
    logic [47:0]        rx_sh, rx_nxt;
    logic               sclk_nxt, mosi_nxt, ss_nxt;
    logic signed [15:0] dx_nxt, dy_nxt, dz_nxt;
    logic               valid_nxt, overrun_nxt;

    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic               tick_accept;
    logic               div_last;
    logic [7:0]         fill_byte;
    logic [2:0]         last_byte;

    // Free-running sample counter; tick is high for the cycle the count is back at 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_cnt == TICK_LAST);
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    // A tick only starts a read in WAIT once the SS-high gap has elapsed.
    assign tick_accept = tick && (state == ST_WAIT) && (phase == PH_IDLE) && (gap_cnt == '0);
    assign div_last    = (div_cnt == DIV_LAST);
    assign fill_byte   = (state == ST_CFG) ? CMD_WR_DATA : 8'h00;
    assign last_byte   = (state == ST_CFG) ? 3'd1 : 3'd6;

    // Next-state logic: sequencer state, SPI frame phase, shifters and outputs.
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        div_nxt     = div_cnt;
        gap_nxt     = (gap_cnt == '0) ? '0 : gap_cnt - 1'b1;
        bit_nxt     = bit_cnt;
        byte_nxt    = byte_cnt;
        tx_nxt      = tx_sh;
        rx_nxt      = rx_sh;
        sclk_nxt    = SCLK;
        mosi_nxt    = MOSI;
        ss_nxt      = SS;
        dx_nxt      = DX;
        dy_nxt      = DY;
        dz_nxt      = DZ;
        valid_nxt   = 1'b0;
        overrun_nxt = OVERRUN | (tick & ~tick_accept);

        unique case (phase)
            PH_IDLE: begin
                unique case (state)
                    ST_CFG: begin
                        ss_nxt    = 1'b0;
                        phase_nxt = PH_SETUP;
                        div_nxt   = '0;
                        bit_nxt   = '0;
                        byte_nxt  = '0;
                        tx_nxt    = CMD_WR_ADDR;
                    end
                    ST_WAIT: begin
                        if (tick_accept) begin
                            state_nxt = ST_READ;
                            ss_nxt    = 1'b0;
                            phase_nxt = PH_SETUP;
                            div_nxt   = '0;
                            bit_nxt   = '0;
                            byte_nxt  = '0;
                            tx_nxt    = CMD_RD;
                        end
                    end
                    ST_PUB: begin
                        // Bytes arrive XL,XH,YL,YH,ZL,ZH; the oldest sits at the top.
                        dx_nxt    = deadband({rx_sh[39:32], rx_sh[47:40]});
                        dy_nxt    = deadband({rx_sh[23:16], rx_sh[31:24]});
                        dz_nxt    = deadband({rx_sh[7:0],   rx_sh[15:8]});
                        valid_nxt = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                    default: begin
                    end
                endcase
            end
            PH_SETUP: begin
                if (div_last) begin
                    phase_nxt = PH_LOW;
                    div_nxt   = '0;
                    sclk_nxt  = 1'b0;
                    mosi_nxt  = tx_sh[7];
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            PH_LOW: begin
                if (div_last) begin
                    phase_nxt = PH_HIGH;
                    div_nxt   = '0;
                    sclk_nxt  = 1'b1;
                    rx_nxt    = {rx_sh[46:0], MISO};
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            PH_HIGH: begin
                if (div_last) begin
                    div_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt == last_byte) begin
                            phase_nxt = PH_HOLD;
                            mosi_nxt  = 1'b0;
                        end else begin
                            phase_nxt = PH_LOW;
                            byte_nxt  = byte_cnt + 1'b1;
                            bit_nxt   = '0;
                            tx_nxt    = fill_byte;
                            sclk_nxt  = 1'b0;
                            mosi_nxt  = fill_byte[7];
                        end
                    end else begin
                        phase_nxt = PH_LOW;
                        bit_nxt   = bit_cnt + 1'b1;
                        tx_nxt    = {tx_sh[6:0], 1'b0};
                        sclk_nxt  = 1'b0;
                        mosi_nxt  = tx_sh[6];
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            PH_HOLD: begin
                if (div_last) begin
                    phase_nxt = PH_IDLE;
                    div_nxt   = '0;
                    ss_nxt    = 1'b1;
                    gap_nxt   = DIV_LAST;
                    state_nxt = (state == ST_CFG) ? ST_WAIT : ST_PUB;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: begin
                phase_nxt = PH_IDLE;
            end
        endcase
    end

    // Control and published outputs; RST returns everything to idle at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_CFG;
            phase    <= PH_IDLE;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            SCLK     <= 1'b1;
            MOSI     <= 1'b0;
            SS       <= 1'b1;
            DX       <= '0;
            DY       <= '0;
            DZ       <= '0;
            VALID    <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            div_cnt  <= div_nxt;
            gap_cnt  <= gap_nxt;
            bit_cnt  <= bit_nxt;
            byte_cnt <= byte_nxt;
            SCLK     <= sclk_nxt;
            MOSI     <= mosi_nxt;
            SS       <= ss_nxt;
            DX       <= dx_nxt;
            DY       <= dy_nxt;
            DZ       <= dz_nxt;
            VALID    <= valid_nxt;
            OVERRUN  <= overrun_nxt;
        end
    end

    // Shift registers are pure data; every frame reloads them before use.
    always_ff @(posedge CLK) begin
        tx_sh <= tx_nxt;
        rx_sh <= rx_nxt;
    end

endmodule
